// File: rtl/msi_bus_pkg.sv
// msi_bus_pkg: shared op codes, arbiter FSM states and MSI line states for the snooping bus.
package msi_bus_pkg;
   typedef enum logic [1:0] {
      OP_NONE       = 2'b00,
      OP_READ_MISS  = 2'b01,
      OP_WRITE_MISS = 2'b10,
      OP_INVALIDATE = 2'b11
   } op_e;
   typedef enum logic [2:0] {
      S_IDLE, S_GRANT, S_BCAST, S_SNOOP, S_WB_MEM, S_RD_MEM, S_DONE
   } state_e;
   typedef enum logic [1:0] {
      INVALID  = 2'b00,
      MODIFIED = 2'b01,
      SHARED   = 2'b10
   } line_e;
endpackage

// File: rtl/msi_bus_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, first eligible requester at or after ptr_i wins.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  eligible_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  win_oh_o,
   output logic [IW-1:0] win_idx_o
);
   always_comb begin
      win_idx_o = '0;
      for (int k = N - 1; k >= 0; k--)
         if (eligible_i[(int'(ptr_i) + k) % N]) win_idx_o = IW'((int'(ptr_i) + k) % N);
      win_oh_o = (|eligible_i) ? (N'(1) << win_idx_o) : '0;
   end
endmodule

// File: rtl/msi_bus_arbiter.sv
// msi_bus_arbiter: round-robin snooping-bus arbiter and transaction sequencer for the MSI caches.
// Optional memory-ack watchdog enabled by defining MSI_ARB_TIMEOUT_EN.
module msi_bus_arbiter import msi_bus_pkg::*; #(
   parameter int N_CACHES       = 4,
   parameter int ADDR_W         = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [N_CACHES-1:0]        req_valid_i,
   input  logic [2*N_CACHES-1:0]      req_op_i,
   input  logic [N_CACHES*ADDR_W-1:0] req_addr_i,
   output logic [N_CACHES-1:0]        grant_o,
   output logic                       bus_read_miss_o,
   output logic                       bus_write_miss_o,
   output logic                       bus_invalidate_o,
   output logic [ADDR_W-1:0]          bus_addr_o,
   output logic [$clog2(N_CACHES)-1:0] bus_owner_o,
   input  logic [N_CACHES-1:0]        snoop_write_back_i,
   input  logic [N_CACHES-1:0]        snoop_abort_i,
   output logic                       mem_req_o,
   output logic                       mem_we_o,
   output logic [ADDR_W-1:0]          mem_addr_o,
   input  logic                       mem_ack_i,
   output logic [N_CACHES-1:0]        done_o,
   output logic                       busy_o,
   output logic                       timeout_err_o
);
   localparam int IW = $clog2(N_CACHES);
   state_e              state_q, state_d;
   op_e                 op_q, op_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [IW-1:0]       owner_q, owner_d, rr_q, rr_d, win_idx;
   logic [N_CACHES-1:0] elig, win_oh, own_oh;
   logic                ab_q, ab_d, mem_req_q, mem_req_d, wb, ab, ack, tmo, skip_rd;
   always_comb begin
      elig = '0;
      for (int i = 0; i < N_CACHES; i++) elig[i] = req_valid_i[i] && req_op_i[2*i +: 2] != OP_NONE;
   end
   rr_arbiter #(.N(N_CACHES), .IW(IW)) u_rr (
      .eligible_i(elig),
      .ptr_i     (rr_q),
      .win_oh_o  (win_oh),
      .win_idx_o (win_idx)
   );
   // The owner never snoops its own transaction.
   assign own_oh  = N_CACHES'(1) << owner_q;
   assign wb      = |(snoop_write_back_i & ~own_oh);
   assign ab      = |(snoop_abort_i & ~own_oh);
   assign ack     = mem_req_q && mem_ack_i;
   assign skip_rd = op_q == OP_INVALIDATE;
`ifdef MSI_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q;
   logic          err_q;
   assign tmo = mem_req_q && !mem_ack_i && cnt_q == CW'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= (mem_req_q && !mem_ack_i && !tmo) ? cnt_q + 1'b1 : '0;
         err_q <= err_q || tmo;
      end
   end
   assign timeout_err_o = err_q;
`else
   assign tmo           = 1'b0;
   assign timeout_err_o = 1'b0;
`endif
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         op_q      <= OP_NONE;
         addr_q    <= '0;
         owner_q   <= '0;
         rr_q      <= '0;
         ab_q      <= 1'b0;
         mem_req_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         owner_q   <= owner_d;
         rr_q      <= rr_d;
         ab_q      <= ab_d;
         mem_req_q <= mem_req_d;
      end
   end
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      addr_d    = addr_q;
      owner_d   = owner_q;
      rr_d      = rr_q;
      ab_d      = ab_q;
      mem_req_d = mem_req_q;
      case (state_q)
         S_IDLE: if (|win_oh) begin
            state_d = S_GRANT;
            op_d    = op_e'(req_op_i[2*win_idx +: 2]);
            addr_d  = req_addr_i[win_idx*ADDR_W +: ADDR_W];
            owner_d = win_idx;
         end
         S_GRANT: begin
            rr_d    = (owner_q == IW'(N_CACHES - 1)) ? '0 : owner_q + 1'b1;
            state_d = S_BCAST;
         end
         S_BCAST: state_d = S_SNOOP;
         S_SNOOP: begin
            ab_d      = ab;
            state_d   = wb ? S_WB_MEM : (skip_rd || ab) ? S_DONE : S_RD_MEM;
            mem_req_d = wb || !(skip_rd || ab);
         end
         S_WB_MEM: if (ack) begin
            mem_req_d = 1'b0;
            state_d   = (ab_q || skip_rd) ? S_DONE : S_RD_MEM;
         end
         // Entering from WB_MEM leaves mem_req low for one cycle before the read starts.
         S_RD_MEM: begin
            mem_req_d = !ack;
            state_d   = ack ? S_DONE : S_RD_MEM;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (tmo) begin
         mem_req_d = 1'b0;
         state_d   = S_DONE;
      end
   end
   always_comb begin
      grant_o          = (state_q == S_GRANT) ? own_oh : '0;
      done_o           = (state_q == S_DONE) ? own_oh : '0;
      bus_read_miss_o  = state_q == S_BCAST && op_q == OP_READ_MISS;
      bus_write_miss_o = state_q == S_BCAST && op_q == OP_WRITE_MISS;
      bus_invalidate_o = state_q == S_BCAST && op_q == OP_INVALIDATE;
      bus_addr_o       = addr_q;
      bus_owner_o      = owner_q;
      mem_addr_o       = addr_q;
      mem_req_o        = mem_req_q;
      mem_we_o         = mem_req_q && state_q == S_WB_MEM;
      busy_o           = state_q != S_IDLE;
   end
endmodule
